// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Owns the single register-file write port. It merges single-cycle pipeline
//   writeback results with long-latency results (divider, load miss path).
//   Long-latency results wait in a small in-order FIFO. At most one
//   registered write is issued per cycle.
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   pipe_valid/pipe_rd/_data  pipeline writeback result for this cycle
//   mc_valid/mc_ready         long-latency handshake; mc_rd/mc_data payload
//   query_rs1/rs2, busy1/2    decode sources vs. pending FIFO destinations
//   pipe_stall                pipeline result not consumed; upstream holds
//   wb_en/wb_reg/wb_data      registered register-file write
//   count                     FIFO occupancy
//
// Handshake: a long-latency transfer happens in every cycle where mc_valid
// and mc_ready are both high at the clock edge. mc_ready depends only on
// reset and on the current occupancy, never on mc_valid, and it does not
// rise for a dequeue in the same cycle. The producer keeps mc_valid and its
// payload stable until the transfer happens. A transfer to register 0
// completes but is discarded.
module wb_port_arbiter #(
  parameter int WIDTH        = 32,
  parameter int REG_COUNT    = 32,
  parameter int REG_BITS     = $clog2(REG_COUNT),
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pipe_valid,
  input  logic [REG_BITS-1:0]         pipe_rd,
  input  logic signed [WIDTH-1:0]     pipe_data,
  input  logic                        mc_valid,
  output logic                        mc_ready,
  input  logic [REG_BITS-1:0]         mc_rd,
  input  logic signed [WIDTH-1:0]     mc_data,
  input  logic [REG_BITS-1:0]         query_rs1,
  input  logic [REG_BITS-1:0]         query_rs2,
  output logic                        busy1,
  output logic                        busy2,
  output logic                        pipe_stall,
  output logic                        wb_en,
  output logic [REG_BITS-1:0]         wb_reg,
  output logic signed [WIDTH-1:0]     wb_data,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int AW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    SEL_IDLE = 2'd0,
    SEL_PIPE = 2'd1,
    SEL_FIFO = 2'd2
  } sel_e;

  logic [REG_BITS-1:0]     mem_rd   [DEPTH];
  logic signed [WIDTH-1:0] mem_data [DEPTH];
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           wr_ptr;
  logic [AW-1:0]           age;
  logic                    enq;
  logic                    deq;
  sel_e                    sel;
  logic [PW-1:0]           off;

  assign mc_ready   = !rst && (count < CW'(DEPTH));
  // Register 0 is never written, so a transfer to it is consumed and dropped.
  assign enq        = mc_valid && mc_ready && (mc_rd != '0);
  assign pipe_stall = (count != '0) && (age == AW'(STARVE_LIMIT));
  assign deq        = (sel == SEL_FIFO);

  // A starved head beats the pipeline. An rd==0 pipeline result counts as idle.
  always_comb begin
    sel = SEL_IDLE;
    if (pipe_stall) begin
      sel = SEL_FIFO;
    end else if (pipe_valid && (pipe_rd != '0)) begin
      sel = SEL_PIPE;
    end else if (count != '0) begin
      sel = SEL_FIFO;
    end
  end

  // Slot i is live when its distance from the read pointer (modulo DEPTH) is
  // below the occupancy. The head counts even while it is being dequeued.
  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if (CW'(off) < count) begin
        if ((query_rs1 != '0) && (mem_rd[i] == query_rs1)) busy1 = 1'b1;
        if ((query_rs2 != '0) && (mem_rd[i] == query_rs2)) busy2 = 1'b1;
      end
    end
  end

  // Payload storage needs no reset. Occupancy decides which slots are valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_rd[wr_ptr]   <= mc_rd;
      mem_data[wr_ptr] <= mc_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      age     <= '0;
      wb_en   <= 1'b0;
      wb_reg  <= '0;
      wb_data <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);

      if (enq && !deq) begin
        count <= count + CW'(1);
      end else if (!enq && deq) begin
        count <= count - CW'(1);
      end

      // Age is the wait time of the current head, so it restarts on every
      // dequeue. It saturates so that pipe_stall stays a simple compare.
      if (deq || (count == '0)) begin
        age <= '0;
      end else if (age != AW'(STARVE_LIMIT)) begin
        age <= age + AW'(1);
      end

      unique case (sel)
        SEL_PIPE: begin
          wb_en   <= 1'b1;
          wb_reg  <= pipe_rd;
          wb_data <= pipe_data;
        end
        SEL_FIFO: begin
          wb_en   <= 1'b1;
          wb_reg  <= mem_rd[rd_ptr];
          wb_data <= mem_data[rd_ptr];
        end
        default: begin
          wb_en   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter.
// Pipeline results always carry data with bit 31 set. Long-latency results
// always carry data with bit 31 clear. The write monitor uses that bit to pick
// the expected queue, so each source is checked in order. Cross-source
// ordering and cycle timing are checked directly at fixed cycles.
module tb_wb_port_arbiter;

  localparam int WIDTH        = 32;
  localparam int REG_BITS     = 5;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;
  localparam int CW           = $clog2(DEPTH + 1);
  localparam int EW           = REG_BITS + WIDTH;

  logic                clk;
  logic                rst;
  logic                pipe_valid;
  logic [REG_BITS-1:0] pipe_rd;
  logic [WIDTH-1:0]    pipe_data;
  logic                mc_valid;
  logic                mc_ready;
  logic [REG_BITS-1:0] mc_rd;
  logic [WIDTH-1:0]    mc_data;
  logic [REG_BITS-1:0] query_rs1;
  logic [REG_BITS-1:0] query_rs2;
  logic                busy1;
  logic                busy2;
  logic                pipe_stall;
  logic                wb_en;
  logic [REG_BITS-1:0] wb_reg;
  logic [WIDTH-1:0]    wb_data;
  logic [CW-1:0]       count;

  logic [EW-1:0] exp_pipe_q[$];
  logic [EW-1:0] exp_mc_q[$];
  logic [EW-1:0] mon_exp;

  int n_checks;
  int n_errors;

  wb_port_arbiter #(
    .WIDTH(WIDTH), .REG_COUNT(32), .REG_BITS(REG_BITS),
    .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_data(mc_data),
    .query_rs1(query_rs1), .query_rs2(query_rs2),
    .busy1(busy1), .busy2(busy2), .pipe_stall(pipe_stall),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .count(count)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- check / driver tasks ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_pipe(input logic v, input logic [REG_BITS-1:0] rd,
                            input logic [WIDTH-1:0] d, input logic expect_write);
    pipe_valid = v;
    pipe_rd    = rd;
    pipe_data  = d;
    if (expect_write) exp_pipe_q.push_back({rd, d});
  endtask

  task automatic drive_mc(input logic v, input logic [REG_BITS-1:0] rd,
                          input logic [WIDTH-1:0] d, input logic expect_write);
    mc_valid = v;
    mc_rd    = rd;
    mc_data  = d;
    if (expect_write) exp_mc_q.push_back({rd, d});
  endtask

  // ---------------- write monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && wb_en) begin
      if (wb_data[31]) begin
        if (exp_pipe_q.size() == 0) begin
          check("wb_pipe_extra", 64'({wb_reg, wb_data}), 64'(0));
        end else begin
          mon_exp = exp_pipe_q.pop_front();
          check("wb_pipe_write", 64'({wb_reg, wb_data}), 64'(mon_exp));
        end
      end else begin
        if (exp_mc_q.size() == 0) begin
          check("wb_mc_extra", 64'({wb_reg, wb_data}), 64'(0));
        end else begin
          mon_exp = exp_mc_q.pop_front();
          check("wb_mc_write", 64'({wb_reg, wb_data}), 64'(mon_exp));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    query_rs1 = 5'd3;
    query_rs2 = 5'd5;
    drive_pipe(1'b0, '0, '0, 1'b0);
    drive_mc(1'b1, 5'd3, 32'h33, 1'b0);

    // Reset then idle
    repeat (3) begin
      tick();
      settle();
      check("rst_wb_en", 64'(wb_en), 64'(0));
      check("rst_wb_reg", 64'(wb_reg), 64'(0));
      check("rst_wb_data", 64'(wb_data), 64'(0));
      check("rst_count", 64'(count), 64'(0));
      check("rst_mc_ready", 64'(mc_ready), 64'(0));
      check("rst_busy1", 64'(busy1), 64'(0));
      check("rst_busy2", 64'(busy2), 64'(0));
      check("rst_pipe_stall", 64'(pipe_stall), 64'(0));
    end
    drive_mc(1'b0, '0, '0, 1'b0);
    tick();
    rst = 1'b0;
    settle();
    check("post_rst_mc_ready", 64'(mc_ready), 64'(1));
    check("post_rst_count", 64'(count), 64'(0));
    check("post_rst_wb_en", 64'(wb_en), 64'(0));

    // Pipeline only
    tick();
    drive_pipe(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1);
    tick();
    drive_pipe(1'b1, 5'd0, 32'h8000_0000, 1'b0);
    settle();
    check("pipe_wb_en", 64'(wb_en), 64'(1));
    check("pipe_wb_reg", 64'(wb_reg), 64'(5));
    check("pipe_wb_data", 64'(wb_data), 64'(32'hDEAD_BEEF));
    tick();
    drive_pipe(1'b0, '0, '0, 1'b0);
    settle();
    check("pipe_rd0_wb_en", 64'(wb_en), 64'(0));

    // Fill (pipeline busy keeps the FIFO from draining), then drain
    query_rs1 = 5'd3;
    query_rs2 = 5'd9;
    for (int k = 0; k < 4; k++) begin
      tick();
      drive_pipe(1'b1, 5'd20, 32'hA000_0000 + 32'(k), 1'b1);
      drive_mc(1'b1, 5'(k + 1), 32'h100 * 32'(k + 1), 1'b1);
      settle();
      check("fill_count", 64'(count), 64'(k));
      check("fill_mc_ready", 64'(mc_ready), 64'(1));
    end
    tick();
    drive_pipe(1'b0, '0, '0, 1'b0);
    drive_mc(1'b1, 5'd5, 32'h500, 1'b0);
    settle();
    check("full_count", 64'(count), 64'(4));
    check("full_mc_ready", 64'(mc_ready), 64'(0));
    check("full_busy1", 64'(busy1), 64'(1));
    check("full_busy2", 64'(busy2), 64'(0));
    tick();
    exp_mc_q.push_back({5'd5, 32'h500});
    settle();
    check("drain_count_a", 64'(count), 64'(3));
    check("drain_mc_ready", 64'(mc_ready), 64'(1));
    tick();
    drive_mc(1'b0, '0, '0, 1'b0);
    settle();
    check("drain_busy1_head", 64'(busy1), 64'(1));
    check("drain_count_b", 64'(count), 64'(3));
    tick();
    settle();
    check("drain_busy1_gone", 64'(busy1), 64'(0));
    check("drain_count_c", 64'(count), 64'(2));
    repeat (3) tick();
    settle();
    check("drain_count_end", 64'(count), 64'(0));
    check("drain_mc_left", 64'(exp_mc_q.size()), 64'(0));

    // Priority: pipeline beats a queued entry
    query_rs1 = 5'd7;
    tick();
    drive_mc(1'b1, 5'd7, 32'h77, 1'b1);
    tick();
    drive_mc(1'b0, '0, '0, 1'b0);
    drive_pipe(1'b1, 5'd9, 32'h8000_0009, 1'b1);
    settle();
    check("prio_busy1", 64'(busy1), 64'(1));
    check("prio_idle_wb_en", 64'(wb_en), 64'(0));
    tick();
    drive_pipe(1'b0, '0, '0, 1'b0);
    settle();
    check("prio_first_reg", 64'(wb_reg), 64'(9));
    check("prio_first_en", 64'(wb_en), 64'(1));
    tick();
    settle();
    check("prio_second_reg", 64'(wb_reg), 64'(7));
    check("prio_second_data", 64'(wb_data), 64'(32'h77));
    check("prio_busy1_clear", 64'(busy1), 64'(0));

    // Long-latency minimum latency
    tick();
    drive_mc(1'b1, 5'd11, 32'h11, 1'b1);
    tick();
    drive_mc(1'b0, '0, '0, 1'b0);
    settle();
    check("lat_n1_wb_en", 64'(wb_en), 64'(0));
    check("lat_n1_count", 64'(count), 64'(1));
    tick();
    settle();
    check("lat_n2_wb_en", 64'(wb_en), 64'(1));
    check("lat_n2_wb_reg", 64'(wb_reg), 64'(11));

    // Starvation under continuous pipeline writes
    tick();
    drive_mc(1'b1, 5'd13, 32'h1300, 1'b1);
    drive_pipe(1'b1, 5'd21, 32'h8000_2100, 1'b1);
    settle();
    check("starve_stall_0", 64'(pipe_stall), 64'(0));
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) drive_mc(1'b0, '0, '0, 1'b0);
      // The cycle-9 result is refused and then re-presented unchanged.
      drive_pipe(1'b1, 5'd21, 32'h8000_2100 + 32'((k == 10) ? 9 : k), (k != 9));
      settle();
      check("starve_stall", 64'(pipe_stall), 64'(k == 9));
      if (k == 10) begin
        check("starve_head_reg", 64'(wb_reg), 64'(13));
        check("starve_head_data", 64'(wb_data), 64'(32'h1300));
        check("starve_count", 64'(count), 64'(0));
      end
    end
    tick();
    drive_pipe(1'b0, '0, '0, 1'b0);
    settle();
    check("starve_held_reg", 64'(wb_reg), 64'(21));
    check("starve_held_data", 64'(wb_data), 64'(32'h8000_2109));

    // Reset mid-queue: queued entries must never be written
    query_rs1 = 5'd2;
    for (int k = 0; k < 3; k++) begin
      tick();
      drive_pipe(1'b1, 5'd22, 32'h8000_3000 + 32'(k), (k < 2));
      drive_mc(1'b1, 5'(k + 1), 32'h3000 + 32'(k), 1'b0);
      settle();
      check("rq_count", 64'(count), 64'(k));
    end
    check("rq_busy1_before", 64'(busy1), 64'(1));
    tick();
    drive_pipe(1'b0, '0, '0, 1'b0);
    drive_mc(1'b0, '0, '0, 1'b0);
    rst = 1'b1;
    settle();
    check("rq_rst_count", 64'(count), 64'(0));
    check("rq_rst_busy1", 64'(busy1), 64'(0));
    check("rq_rst_wb_en", 64'(wb_en), 64'(0));
    check("rq_rst_mc_ready", 64'(mc_ready), 64'(0));
    tick();
    rst = 1'b0;
    settle();
    check("rq_post_count", 64'(count), 64'(0));
    check("rq_post_busy1", 64'(busy1), 64'(0));
    check("rq_post_mc_ready", 64'(mc_ready), 64'(1));
    repeat (5) begin
      tick();
      settle();
      check("rq_post_wb_en", 64'(wb_en), 64'(0));
    end

    check("pipe_q_left", 64'(exp_pipe_q.size()), 64'(0));
    check("mc_q_left", 64'(exp_mc_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
